// File: rtl/game_score_timer.sv
// game_score_timer: round control for the score/time display.
// Owns the round FSM, a one-second prescaler, a down-counting round
// timer and a saturating hit counter. Every output is a register so the
// display driver downstream always samples settled binary values.
module game_score_timer #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int GAME_SECONDS = 60,
    parameter int MAX_SCORE    = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hit,
    input  logic       pause,
    output logic [6:0] Score,
    output logic [6:0] Time,
    output logic       running,
    output logic       game_over
);

    localparam int PW = ($clog2(CLK_HZ) < 1) ? 1 : $clog2(CLK_HZ);

    localparam logic [PW-1:0] PCNT_MAX  = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PCNT_ZERO = PW'(0);
    localparam logic [PW-1:0] PCNT_ONE  = PW'(1);
    localparam logic [6:0]    TIME_INIT = 7'(GAME_SECONDS);
    localparam logic [6:0]    SCORE_MAX = 7'(MAX_SCORE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [PW-1:0] pcnt_r;
    logic [PW-1:0] pcnt_nxt_s;
    logic [6:0]    score_r;
    logic [6:0]    score_nxt_s;
    logic [6:0]    time_r;
    logic [6:0]    time_nxt_s;
    logic          running_r;
    logic          running_nxt_s;
    logic          game_over_r;
    logic          game_over_nxt_s;
    logic          tick_s;

    // One-second strobe: last prescaler count of a RUN cycle.
    assign tick_s = (state_r == ST_RUN) && (pcnt_r == PCNT_MAX);

    // Next-state, prescaler, timer and score update for the current edge.
    always_comb begin
        state_nxt_s = state_r;
        pcnt_nxt_s  = pcnt_r;
        score_nxt_s = score_r;
        time_nxt_s  = time_r;

        case (state_r)
            ST_IDLE, ST_OVER: begin
                // start also swallows a coincident hit: score restarts at 0
                if (start) begin
                    state_nxt_s = ST_RUN;
                    pcnt_nxt_s  = PCNT_ZERO;
                    score_nxt_s = 7'd0;
                    time_nxt_s  = TIME_INIT;
                end else begin
                    state_nxt_s = state_r;
                end
            end

            ST_RUN: begin
                if (tick_s) begin
                    pcnt_nxt_s = PCNT_ZERO;
                end else begin
                    pcnt_nxt_s = pcnt_r + PCNT_ONE;
                end

                if (hit && (score_r < SCORE_MAX)) begin
                    score_nxt_s = score_r + 7'd1;
                end else begin
                    score_nxt_s = score_r;
                end

                // A tick is applied before a coincident pause; the final
                // tick ends the round and drops the pause.
                if (tick_s) begin
                    if (time_r <= 7'd1) begin
                        time_nxt_s  = 7'd0;
                        state_nxt_s = ST_OVER;
                    end else begin
                        time_nxt_s  = time_r - 7'd1;
                        if (pause) begin
                            state_nxt_s = ST_PAUSE;
                        end else begin
                            state_nxt_s = ST_RUN;
                        end
                    end
                end else begin
                    if (pause) begin
                        state_nxt_s = ST_PAUSE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
            end

            ST_PAUSE: begin
                // Prescaler holds; it resumes from the held count.
                if (pause) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_PAUSE;
                end
            end

            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        running_nxt_s   = (state_nxt_s == ST_RUN);
        game_over_nxt_s = (state_nxt_s == ST_OVER);
    end

    // State, counters and registered state decodes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            pcnt_r      <= PCNT_ZERO;
            score_r     <= 7'd0;
            time_r      <= TIME_INIT;
            running_r   <= 1'b0;
            game_over_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            pcnt_r      <= pcnt_nxt_s;
            score_r     <= score_nxt_s;
            time_r      <= time_nxt_s;
            running_r   <= running_nxt_s;
            game_over_r <= game_over_nxt_s;
        end
    end

    assign Score     = score_r;
    assign Time      = time_r;
    assign running   = running_r;
    assign game_over = game_over_r;

endmodule

// File: tb/tb_game_score_timer.sv
// tb_game_score_timer: directed scenarios plus randomized pulses, checked
// against a round model that derives the display values from counts of
// RUN edges and hits rather than from a prescaler.
module tb_game_score_timer;

    localparam int CLK_HZ = 10;
    localparam int GS     = 3;
    localparam int MAXS   = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       hit;
    logic       pause;
    logic [6:0] Score;
    logic [6:0] Time;
    logic       running;
    logic       game_over;

    int n_checks = 0;
    int n_errors = 0;

    // Model: 0 idle, 1 run, 2 pause, 3 over.
    int m_mode;
    int m_hits;
    int m_run_edges;
    int m_time;

    game_score_timer #(
        .CLK_HZ(CLK_HZ),
        .GAME_SECONDS(GS),
        .MAX_SCORE(MAXS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .hit(hit),
        .pause(pause),
        .Score(Score),
        .Time(Time),
        .running(running),
        .game_over(game_over)
    );

    // 10-unit clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode      = 0;
        m_hits      = 0;
        m_run_edges = 0;
        m_time      = GS;
    endtask

    // Remaining time is the round length minus whole seconds of RUN edges.
    task automatic model_edge(input bit s, input bit h, input bit p);
        case (m_mode)
            0, 3: begin
                if (s) begin
                    m_mode      = 1;
                    m_hits      = 0;
                    m_run_edges = 0;
                    m_time      = GS;
                end
            end
            1: begin
                m_run_edges++;
                if (h) m_hits++;
                m_time = GS - m_run_edges / CLK_HZ;
                if (m_time == 0) m_mode = 3;
                else if (p) m_mode = 2;
            end
            2: begin
                if (p) m_mode = 1;
            end
            default: m_mode = 0;
        endcase
    endtask

    task automatic check_all(input string tag);
        int exp_score;
        exp_score = (m_hits > MAXS) ? MAXS : m_hits;
        chk({tag, ".score"}, 32'(Score), exp_score);
        chk({tag, ".time"}, 32'(Time), m_time);
        chk({tag, ".running"}, 32'(running), (m_mode == 1) ? 1 : 0);
        chk({tag, ".game_over"}, 32'(game_over), (m_mode == 3) ? 1 : 0);
    endtask

    // One clock edge with the given pulses, then model update and check.
    task automatic cyc(input bit s, input bit h, input bit p);
        start = s;
        hit   = h;
        pause = p;
        @(posedge clk);
        #1;
        model_edge(s, h, p);
        check_all("cyc");
        start = 1'b0;
        hit   = 1'b0;
        pause = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        #2;
        rst = 1'b0;
    endtask

    initial begin
        int exp_sat[7];
        bit rs;
        bit rh;
        bit rp;

        exp_sat = '{1, 2, 3, 4, 5, 5, 5};
        rst   = 1'b1;
        start = 1'b0;
        hit   = 1'b0;
        pause = 1'b0;
        #1;
        model_reset();
        check_all("por");
        #11;
        rst = 1'b0;

        // Hit and pause ignored in IDLE.
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);

        // Round up to Score=2, Time=1, then reset mid-cycle.
        cyc(1'b1, 1'b0, 1'b0);
        chk("start_run", 32'(running), 1);
        chk("start_time", 32'(Time), GS);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        idle_cycles(18);
        chk("pre_rst_time", 32'(Time), 1);
        chk("pre_rst_score", 32'(Score), 2);
        do_reset();
        chk("rst_score", 32'(Score), 0);
        chk("rst_time", 32'(Time), GS);

        // Full round; 4 hits then a hit on the final tick (edge 30).
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0);
        idle_cycles(5);
        chk("edge9_time", 32'(Time), 3);
        cyc(1'b0, 1'b0, 1'b0);
        chk("edge10_time", 32'(Time), 2);
        idle_cycles(9);
        cyc(1'b0, 1'b0, 1'b0);
        chk("edge20_time", 32'(Time), 1);
        idle_cycles(9);
        cyc(1'b0, 1'b1, 1'b0);
        chk("final_time", 32'(Time), 0);
        chk("final_over", 32'(game_over), 1);
        chk("final_running", 32'(running), 0);
        chk("final_hit_score", 32'(Score), 5);
        cyc(1'b0, 1'b1, 1'b1);
        chk("over_hold_score", 32'(Score), 5);

        // Saturation, ignored start, pause on a non-final tick.
        cyc(1'b1, 1'b0, 1'b0);
        chk("restart_score", 32'(Score), 0);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            chk("sat_score", 32'(Score), exp_sat[i]);
        end
        cyc(1'b1, 1'b0, 1'b0);
        chk("mid_start_running", 32'(running), 1);
        chk("mid_start_score", 32'(Score), 5);
        idle_cycles(11);
        cyc(1'b0, 1'b0, 1'b1);
        chk("tick_pause_time", 32'(Time), 1);
        chk("tick_pause_running", 32'(running), 0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        idle_cycles(12);

        // Pause at edge 5, resume at edge 25: first decrement at edge 30.
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        idle_cycles(10);
        cyc(1'b0, 1'b1, 1'b0);
        idle_cycles(8);
        cyc(1'b0, 1'b0, 1'b1);
        chk("pause_score", 32'(Score), 4);
        idle_cycles(3);
        cyc(1'b0, 1'b0, 1'b0);
        chk("edge29_time", 32'(Time), 3);
        cyc(1'b0, 1'b0, 1'b0);
        chk("edge30_time", 32'(Time), 2);
        idle_cycles(20);
        chk("over_score4", 32'(Score), 4);
        cyc(1'b1, 1'b1, 1'b0);
        chk("over_restart_score", 32'(Score), 0);
        chk("over_restart_time", 32'(Time), GS);
        chk("over_restart_running", 32'(running), 1);

        // Randomized pulses with occasional asynchronous reset.
        for (int i = 0; i < 4000; i++) begin
            rs = ($urandom_range(0, 39) == 0);
            rh = ($urandom_range(0, 3) == 0);
            rp = ($urandom_range(0, 29) == 0);
            cyc(rs, rh, rp);
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/game_score_timer.md
# game_score_timer

Game-control stage that sits directly upstream of the seven-segment display driver. It produces the 7-bit `Score` and `Time` values the display driver shows. It owns the round state machine, a one-second prescaler, a down-counting round timer, and a saturating hit counter. All outputs are registered, so the display stage samples stable binary values.

## Interface
- `CLK_HZ`, default 100_000_000: clock cycles per one-second tick; range 2..2^27.
- `GAME_SECONDS`, default 60: round length in seconds; range 1..99.
- `MAX_SCORE`, default 99: score saturation value; range 1..99.
- `clk`  in  1  system clock; the only clock in the block.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  single-cycle pulse, synchronous to `clk`, from the debounced start key.
- `hit`  in  1  single-cycle pulse, synchronous to `clk`; scores one point.
- `pause`  in  1  single-cycle pulse, synchronous to `clk`; toggles pause.
- `Score`  out  7  current score, binary, 0..MAX_SCORE.
- `Time`  out  7  seconds remaining, binary, 0..GAME_SECONDS.
- `running`  out  1  high while in RUN.
- `game_over`  out  1  high while in OVER.

## Operation
- States:
  - IDLE: waiting for first round.
  - RUN: round in progress.
  - PAUSE: round frozen.
  - OVER: round finished.
- Prescaler `pcnt`: width is ceil(log2(CLK_HZ)).
  - Counts 0..CLK_HZ-1 only in RUN and wraps to 0.
  - `tick` is asserted on the cycle where `pcnt == CLK_HZ-1` and state is RUN.
  - `pcnt` holds its value in PAUSE.
  - `pcnt` is cleared on every round start.
- Transitions (evaluated at each rising edge):
  - IDLE or OVER, `start=1`: go to RUN. Load `Score<=0`, `Time<=GAME_SECONDS`, `pcnt<=0`.
  - RUN, `pause=1`: go to PAUSE.
  - PAUSE, `pause=1`: go to RUN. The prescaler resumes from its held value.
  - RUN, `tick=1` and `Time==1`: `Time<=0` and go to OVER.
  - RUN, `tick=1` and `Time>1`: `Time<=Time-1`.
  - `start` in RUN or PAUSE is ignored; there is no mid-round restart.
  - `pause` in IDLE or OVER is ignored.
- Scoring:
  - In RUN, `hit=1` gives `Score<=Score+1`, saturating at MAX_SCORE. A hit while `Score==MAX_SCORE` leaves `Score` unchanged.
  - `hit` is ignored in IDLE, PAUSE and OVER.
- Simultaneous events:
  - `hit` together with the final tick: the hit is counted and the state still goes to OVER.
  - `pause` together with a tick in RUN: the tick is applied (Time decrements, or the round ends if `Time==1`), then the pause takes effect. If the tick ends the round, the state goes to OVER and the pause is dropped.
  - `hit` together with `pause` in RUN: the hit is counted.
  - `start` together with `hit` in IDLE or OVER: the start loads `Score=0`; the hit is ignored.
- In OVER, `Score` and `Time=0` hold until the next `start`.
- Arithmetic is unsigned. `Time` never underflows; the decrement occurs only when `Time>=1`.

## Timing
- Reset values, applied immediately on `rst` assertion regardless of clock: state IDLE, `Score=0`, `Time=GAME_SECONDS`, `pcnt=0`, `running=0`, `game_over=0`.
- Reset mid-round aborts the round with no residual state.
- Output decoding: `running` and `game_over` are registered state decodes and change on the same edge as the state.
- Start latency: a `start` pulse sampled at edge k gives RUN, `running=1` and `Time=GAME_SECONDS` after edge k.
- First decrement: occurs at edge k+CLK_HZ, counting edges k+1..k+CLK_HZ as the prescaler's CLK_HZ RUN cycles.
- Round length: an unpaused round ends exactly GAME_SECONDS*CLK_HZ cycles after the start edge. `game_over` rises on the same edge `Time` becomes 0.
- Pause accounting: cycles spent in PAUSE do not count toward the prescaler.
- Hit latency: one edge; `Score` updates on the edge that samples `hit`.
- Pulse width: each input pulse is acted on once per sampled high cycle. Upstream must guarantee single-cycle pulses; a multi-cycle `hit` scores once per cycle.

## Test plan
All scenarios use CLK_HZ=10, GAME_SECONDS=3, MAX_SCORE=5.
- Reset: assert `rst` asynchronously mid-cycle during RUN with `Score=2`, `Time=1` -> immediately `Score=0`, `Time=3`, `running=0`, `game_over=0`.
- Full round: `start` at edge 0 with no other input -> `Time` goes 3→2 at edge 10, 2→1 at edge 20, 1→0 at edge 30. At edge 30 `game_over=1` and `running=0`.
- Scoring and saturation: 7 `hit` pulses in RUN -> `Score` goes 1,2,3,4,5,5,5. A `hit` in IDLE, PAUSE or OVER leaves `Score` unchanged.
- Pause: `start` at edge 0, `pause` at edge 5, `pause` at edge 25 -> the first decrement (`Time`=2) lands at edge 30. Hits during PAUSE are ignored.
- Simultaneous events:
  - `hit` on the final-tick cycle -> `Score` increments and `game_over=1` on the same edge.
  - `pause` on a non-final tick cycle -> `Time` decrements and the state becomes PAUSE.
- Restart: `start` in OVER with `Score=4` -> RUN with `Score=0`, `Time=3`. A `start` pulse during RUN causes no change.
